rr_decoder_arbiter: RTL and testbench

RR_DECODER_ARBITER -- requirements
Module: rr_decoder_arbiter

---
 rtl/rr_decoder_arbiter.sv | 143 ++++++++++++++
 tb/tb_rr_decoder_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rr_decoder_arbiter.sv
// rr_decoder_arbiter
//   Four-requester round-robin arbiter with a 2-to-4 grant decoder and a
//   per-owner hold limit. An owner keeps the grant while it requests, up to
//   MAX_HOLD consecutive cycles. Every grant ends with one RELEASE cycle in
//   which nobody is granted. Requests from non-owners never preempt.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req[3:0]   level requests, bit i = requester i
//   gnt[3:0]   one-hot grant, decoded from gnt_idx when gnt_valid, else 0
//   gnt_idx    binary index of the current (or most recent) owner
//   gnt_valid  grant active
//   timeout    one-cycle pulse when a grant is force-released at MAX_HOLD
//
// MAX_HOLD must lie in 1..255.

module rr_decoder_arbiter #(
   parameter int MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   localparam logic [7:0] MAX_HOLD_C = MAX_HOLD[7:0];

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t     state_q,     state_d;
   logic [1:0] last_idx_q,  last_idx_d;
   logic [7:0] hold_cnt_q,  hold_cnt_d;
   logic [1:0] gnt_idx_q,   gnt_idx_d;
   logic       gnt_valid_q, gnt_valid_d;
   logic       timeout_q,   timeout_d;

   // Search last+1, last+2, last+3, last+4 (mod 4). Iterating from the far
   // end lets the nearest requester overwrite the result, so it wins. The
   // previous owner (offset 4) only wins when it is the sole requester.
   function automatic logic [1:0] pick_winner(input logic [1:0] last,
                                              input logic [3:0] r);
      logic [1:0] cand;
      pick_winner = last;
      for (int k = 4; k >= 1; k--) begin
         cand = last + 2'(k);
         if (r[cand]) pick_winner = cand;
      end
   endfunction

   always_comb begin
      state_d     = state_q;
      last_idx_d  = last_idx_q;
      hold_cnt_d  = hold_cnt_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (req != 4'b0000) begin
               state_d     = GRANT;
               gnt_idx_d   = pick_winner(last_idx_q, req);
               gnt_valid_d = 1'b1;
               hold_cnt_d  = 8'd1;
            end
         end

         GRANT: begin
            // Owner drop is checked first so a drop on the final allowed
            // cycle is an ordinary release without a timeout pulse.
            if (!req[gnt_idx_q]) begin
               state_d     = RELEASE;
               gnt_valid_d = 1'b0;
               last_idx_d  = gnt_idx_q;
               hold_cnt_d  = 8'd0;
            end else if (hold_cnt_q < MAX_HOLD_C) begin
               hold_cnt_d  = hold_cnt_q + 8'd1;
            end else begin
               state_d     = RELEASE;
               gnt_valid_d = 1'b0;
               timeout_d   = 1'b1;
               last_idx_d  = gnt_idx_q;
               hold_cnt_d  = 8'd0;
            end
         end

         RELEASE: begin
            if (req != 4'b0000) begin
               state_d     = GRANT;
               gnt_idx_d   = pick_winner(last_idx_q, req);
               gnt_valid_d = 1'b1;
               hold_cnt_d  = 8'd1;
            end else begin
               state_d     = IDLE;
            end
         end

         default: begin
            state_d     = IDLE;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         last_idx_q  <= 2'd3;  // first search after reset starts at requester 0
         hold_cnt_q  <= 8'd0;
         gnt_idx_q   <= 2'd0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         last_idx_q  <= last_idx_d;
         hold_cnt_q  <= hold_cnt_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
      end
   end

   // Decoder driven only by registered state, so gnt follows the async reset
   // immediately and can never be decoded straight from req.
   always_comb begin
      gnt = 4'b0000;
      if (gnt_valid_q) gnt[gnt_idx_q] = 1'b1;
   end

   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_decoder_arbiter.sv
module tb_rr_decoder_arbiter;

   logic clk = 1'b0;
   logic rst;
   logic [3:0] req8, req2, req1;
   logic [3:0] gnt8, gnt2, gnt1;
   logic [1:0] idx8, idx2, idx1;
   logic       v8, v2, v1;
   logic       to8, to2, to1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   rr_decoder_arbiter #(.MAX_HOLD(8)) u8 (
      .clk(clk), .rst(rst), .req(req8), .gnt(gnt8),
      .gnt_idx(idx8), .gnt_valid(v8), .timeout(to8));
   rr_decoder_arbiter #(.MAX_HOLD(2)) u2 (
      .clk(clk), .rst(rst), .req(req2), .gnt(gnt2),
      .gnt_idx(idx2), .gnt_valid(v2), .timeout(to2));
   rr_decoder_arbiter #(.MAX_HOLD(1)) u1 (
      .clk(clk), .rst(rst), .req(req1), .gnt(gnt1),
      .gnt_idx(idx1), .gnt_valid(v1), .timeout(to1));

   typedef struct {
      int         sel;   // 0: MAX_HOLD=8, 1: MAX_HOLD=2, 2: MAX_HOLD=1
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] idx;
      logic       vld;
      logic       to;
      string      name;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(int sel, logic [3:0] r, logic [3:0] g,
                               logic [1:0] i, logic v, logic t, string n);
      vec_t e;
      e.sel = sel; e.req = r; e.gnt = g; e.idx = i; e.vld = v; e.to = t; e.name = n;
      vecs.push_back(e);
   endfunction

   task automatic chk(string n, int sel, logic [3:0] g, logic [1:0] i,
                      logic v, logic t);
      logic [3:0] ag;
      logic [1:0] ai;
      logic       av, at;
      case (sel)
         0:       begin ag = gnt8; ai = idx8; av = v8; at = to8; end
         1:       begin ag = gnt2; ai = idx2; av = v2; at = to2; end
         default: begin ag = gnt1; ai = idx1; av = v1; at = to1; end
      endcase
      tests++;
      if (ag !== g || ai !== i || av !== v || at !== t) begin
         fails++;
         $display("FAIL %s: got gnt=%b idx=%0d vld=%b to=%b, want gnt=%b idx=%0d vld=%b to=%b",
                  n, ag, ai, av, at, g, i, v, t);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are checked
   // 1 time unit after the following rising edge.
   task automatic step(int sel, logic [3:0] r);
      req8 = (sel == 0) ? r : 4'b0000;
      req2 = (sel == 1) ? r : 4'b0000;
      req1 = (sel == 2) ? r : 4'b0000;
      @(posedge clk);
      #1;
   endtask

   // Per-cycle invariants on every instance: gnt is zero or the decode of
   // gnt_idx, and timeout never stays high two cycles running.
   logic pto8 = 1'b0, pto2 = 1'b0, pto1 = 1'b0;

   task automatic inv(string n, logic [3:0] g, logic [1:0] i, logic v,
                      logic t, logic pt);
      logic [3:0] want;
      want = 4'b0000;
      if (v) want[i] = 1'b1;
      tests++;
      if (g !== want || (t && pt)) begin
         fails++;
         $display("FAIL %s @%0t: gnt=%b vld=%b idx=%0d to=%b prev_to=%b, want gnt=%b",
                  n, $time, g, v, i, t, pt, want);
      end
   endtask

   always @(negedge clk) begin
      inv("inv_mh8", gnt8, idx8, v8, to8, pto8);
      inv("inv_mh2", gnt2, idx2, v2, to2, pto2);
      inv("inv_mh1", gnt1, idx1, v1, to1, pto1);
      pto8 = to8; pto2 = to2; pto1 = to1;
   end

   initial begin
      rst = 1'b1; req8 = '0; req2 = '0; req1 = '0;

      // ---- MAX_HOLD=8, req=0001 held: 8 grant cycles, timeout, regrant
      add(0, 4'b0001, 4'b0001, 2'd0, 1, 0, "mh8_first_gnt");
      for (int k = 2; k <= 8; k++) add(0, 4'b0001, 4'b0001, 2'd0, 1, 0, "mh8_hold");
      add(0, 4'b0001, 4'b0000, 2'd0, 0, 1, "mh8_timeout");
      add(0, 4'b0001, 4'b0001, 2'd0, 1, 0, "mh8_sole_regrant");
      add(0, 4'b0000, 4'b0000, 2'd0, 0, 0, "mh8_drop_release");
      add(0, 4'b0000, 4'b0000, 2'd0, 0, 0, "mh8_idle");
      // ---- owner 2 for 3 cycles, drop, then 0011 wraps from 3 to 0
      add(0, 4'b0100, 4'b0100, 2'd2, 1, 0, "own2_gnt");
      add(0, 4'b0100, 4'b0100, 2'd2, 1, 0, "own2_hold2");
      add(0, 4'b0100, 4'b0100, 2'd2, 1, 0, "own2_hold3");
      add(0, 4'b0000, 4'b0000, 2'd2, 0, 0, "own2_release_no_to");
      add(0, 4'b0011, 4'b0001, 2'd0, 1, 0, "wrap_to_0");
      add(0, 4'b0000, 4'b0000, 2'd0, 0, 0, "wrap_release");
      add(0, 4'b0000, 4'b0000, 2'd0, 0, 0, "wrap_idle");
      // ---- MAX_HOLD=2, req=1111: order 0,1,2,3,0 with timeouts
      for (int o = 0; o < 4; o++) begin
         logic [3:0] g;
         g = 4'b0001 << o;
         add(1, 4'b1111, g, 2'(o), 1, 0, "rr_gnt_a");
         add(1, 4'b1111, g, 2'(o), 1, 0, "rr_gnt_b");
         add(1, 4'b1111, 4'b0000, 2'(o), 0, 1, "rr_timeout");
      end
      add(1, 4'b1111, 4'b0001, 2'd0, 1, 0, "rr_back_to_0");
      add(1, 4'b1111, 4'b0001, 2'd0, 1, 0, "rr_back_to_0_b");
      // owner drops on its final allowed cycle: plain release, no timeout
      add(1, 4'b0000, 4'b0000, 2'd0, 0, 0, "drop_at_max_no_to");
      add(1, 4'b0000, 4'b0000, 2'd0, 0, 0, "mh2_idle");
      // ---- MAX_HOLD=1, req=0010 held: alternating grant/timeout
      for (int k = 0; k < 3; k++) begin
         add(2, 4'b0010, 4'b0010, 2'd1, 1, 0, "mh1_gnt");
         add(2, 4'b0010, 4'b0000, 2'd1, 0, 1, "mh1_timeout");
      end
      add(2, 4'b0000, 4'b0000, 2'd1, 0, 0, "mh1_idle");

      // Reset values must appear without any clock edge.
      #1;
      chk("reset_mh8", 0, 4'b0000, 2'd0, 0, 0);
      chk("reset_mh2", 1, 4'b0000, 2'd0, 0, 0);
      chk("reset_mh1", 2, 4'b0000, 2'd0, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Idle with no request stays idle.
      step(0, 4'b0000);
      chk("idle_no_req", 0, 4'b0000, 2'd0, 0, 0);

      foreach (vecs[n]) begin
         step(vecs[n].sel, vecs[n].req);
         chk(vecs[n].name, vecs[n].sel, vecs[n].gnt, vecs[n].idx, vecs[n].vld, vecs[n].to);
      end

      // ---- async reset mid-grant of requester 3 (last owner was 0)
      step(0, 4'b1000);
      chk("own3_gnt", 0, 4'b1000, 2'd3, 1, 0);
      step(0, 4'b1000);
      chk("own3_hold", 0, 4'b1000, 2'd3, 1, 0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_drop", 0, 4'b0000, 2'd0, 0, 0);
      @(posedge clk);
      #1;
      chk("rst_held_over_edge", 0, 4'b0000, 2'd0, 0, 0);
      rst = 1'b0;
      step(0, 4'b1001);
      chk("post_rst_search_from_0", 0, 4'b0001, 2'd0, 1, 0);
      step(0, 4'b0000);
      chk("post_rst_release", 0, 4'b0000, 2'd0, 0, 0);

      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
